// File: rtl/flag_unit.sv
// flag_unit: keeps the processor status register (PSR) and decides branch conditions.
//
// The PSR holds {N,Z,F,L,C} and is loaded from the ALU flags under a per-flag mask.
// The 16 CR16-style condition codes are tested against the "effective" flags.
// The effective flags are the PSR plus any write happening in the same cycle.
// A compare can therefore be followed directly by a branch without a stall.
// The decision is registered and returned over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   alu_flags       {N,Z,F,L,C} from the ALU
//   flag_wr_valid   capture masked alu_flags this cycle
//   flag_wr_mask    per-flag update enable (same bit order)
//   cond_req_valid  evaluation request; cond_code is sampled on the handshake
//   cond_req_ready  request can be accepted
//   cond_code       condition code, 0..15
//   cond_rsp_valid  decision available
//   cond_rsp_ready  consumer accepts the decision
//   cond_taken      registered decision
//   scond_result    zero-extended cond_taken for Scond writeback
//   psr_flags       current PSR contents
//   psr_wr_en       (FLAG_UNIT_PSR_WRITE_EN only) direct unmasked PSR load, wins over flag_wr_valid
//   psr_wr_data     (FLAG_UNIT_PSR_WRITE_EN only) value for the direct load
//
// Optional feature macro: FLAG_UNIT_PSR_WRITE_EN

module flag_unit #(
    parameter int unsigned WIDTH_DATA  = 16,
    parameter int unsigned WIDTH_COND  = 4,
    parameter int unsigned WIDTH_FLAGS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH_FLAGS-1:0] alu_flags,
    input  logic                   flag_wr_valid,
    input  logic [WIDTH_FLAGS-1:0] flag_wr_mask,
    input  logic                   cond_req_valid,
    output logic                   cond_req_ready,
    input  logic [WIDTH_COND-1:0]  cond_code,
    output logic                   cond_rsp_valid,
    input  logic                   cond_rsp_ready,
    output logic                   cond_taken,
    output logic [WIDTH_DATA-1:0]  scond_result,
`ifdef FLAG_UNIT_PSR_WRITE_EN
    input  logic                   psr_wr_en,
    input  logic [WIDTH_FLAGS-1:0] psr_wr_data,
`endif
    output logic [WIDTH_FLAGS-1:0] psr_flags
);

    // Flag bit positions in the PSR.
    localparam int unsigned FlagC = 0;
    localparam int unsigned FlagL = 1;
    localparam int unsigned FlagF = 2;
    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagN = 4;

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e                 state_q;
    logic [WIDTH_FLAGS-1:0] psr_q;
    logic [WIDTH_FLAGS-1:0] psr_d;
    logic                   taken_q;
    logic                   cond_true;
    logic                   req_accept;

    // Next PSR value. It also serves as the bypass for same-cycle condition evaluation.
    always_comb begin
        psr_d = psr_q;
`ifdef FLAG_UNIT_PSR_WRITE_EN
        if (psr_wr_en) begin
            psr_d = psr_wr_data;
        end else if (flag_wr_valid) begin
            psr_d = (psr_q & ~flag_wr_mask) | (alu_flags & flag_wr_mask);
        end
`else
        if (flag_wr_valid) begin
            psr_d = (psr_q & ~flag_wr_mask) | (alu_flags & flag_wr_mask);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psr_q <= '0;
        end else begin
            psr_q <= psr_d;
        end
    end

    // Condition table, evaluated on the effective (bypassed) flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond_code)
            4'd0:    cond_true = psr_d[FlagZ];
            4'd1:    cond_true = !psr_d[FlagZ];
            4'd2:    cond_true = psr_d[FlagC];
            4'd3:    cond_true = !psr_d[FlagC];
            4'd4:    cond_true = psr_d[FlagL];
            4'd5:    cond_true = !psr_d[FlagL];
            4'd6:    cond_true = psr_d[FlagN];
            4'd7:    cond_true = !psr_d[FlagN];
            4'd8:    cond_true = psr_d[FlagF];
            4'd9:    cond_true = !psr_d[FlagF];
            4'd10:   cond_true = !psr_d[FlagL] && !psr_d[FlagZ];
            4'd11:   cond_true = psr_d[FlagL] || psr_d[FlagZ];
            4'd12:   cond_true = !psr_d[FlagN] && !psr_d[FlagZ];
            4'd13:   cond_true = psr_d[FlagN] || psr_d[FlagZ];
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // In RESP a new request is only taken when the current response is consumed.
    // This allows back-to-back decisions without a bubble.
    assign cond_req_ready = (state_q == StIdle) ? 1'b1 : cond_rsp_ready;
    assign req_accept     = cond_req_valid && cond_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            taken_q <= 1'b0;
        end else begin
            if (req_accept) begin
                state_q <= StResp;
                taken_q <= cond_true;
            end else if (state_q == StResp && cond_rsp_ready) begin
                state_q <= StIdle;
            end
        end
    end

    assign cond_rsp_valid = (state_q == StResp);
    assign cond_taken     = taken_q;
    assign scond_result   = {{(WIDTH_DATA-1){1'b0}}, taken_q};
    assign psr_flags      = psr_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  alu_flags;
    logic        flag_wr_valid;
    logic [4:0]  flag_wr_mask;
    logic        cond_req_valid;
    logic        cond_req_ready;
    logic [3:0]  cond_code;
    logic        cond_rsp_valid;
    logic        cond_rsp_ready;
    logic        cond_taken;
    logic [15:0] scond_result;
    logic [4:0]  psr_flags;
`ifdef FLAG_UNIT_PSR_WRITE_EN
    logic        psr_wr_en;
    logic [4:0]  psr_wr_data;
`endif

    int checks = 0;
    int errors = 0;

    flag_unit dut (
        .clk            (clk),
        .rst            (rst),
        .alu_flags      (alu_flags),
        .flag_wr_valid  (flag_wr_valid),
        .flag_wr_mask   (flag_wr_mask),
        .cond_req_valid (cond_req_valid),
        .cond_req_ready (cond_req_ready),
        .cond_code      (cond_code),
        .cond_rsp_valid (cond_rsp_valid),
        .cond_rsp_ready (cond_rsp_ready),
        .cond_taken     (cond_taken),
        .scond_result   (scond_result),
`ifdef FLAG_UNIT_PSR_WRITE_EN
        .psr_wr_en      (psr_wr_en),
        .psr_wr_data    (psr_wr_data),
`endif
        .psr_flags      (psr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [4:0] mask;
        logic [4:0] alu;
        logic [3:0] cc;
        logic       exp_taken;
        logic [4:0] exp_psr;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wv, input logic [4:0] mask, input logic [4:0] alu,
                                input logic [3:0] cc, input logic t, input logic [4:0] p);
        vec_t v;
        v.wv = wv; v.mask = mask; v.alu = alu; v.cc = cc; v.exp_taken = t; v.exp_psr = p;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // PSR state is carried from vector to vector; values are {N,Z,F,L,C}.
        vecs[0]  = mk(1'b0, 5'b00000, 5'b00000, 4'd14, 1'b1, 5'b00000);
        vecs[1]  = mk(1'b0, 5'b00000, 5'b00000, 4'd15, 1'b0, 5'b00000);
        vecs[2]  = mk(1'b1, 5'b11111, 5'b01000, 4'd0,  1'b1, 5'b01000);
        vecs[3]  = mk(1'b0, 5'b00000, 5'b00000, 4'd1,  1'b0, 5'b01000);
        vecs[4]  = mk(1'b1, 5'b11111, 5'b11111, 4'd13, 1'b1, 5'b11111);
        vecs[5]  = mk(1'b1, 5'b00100, 5'b00000, 4'd9,  1'b1, 5'b11011);
        vecs[6]  = mk(1'b0, 5'b00000, 5'b00000, 4'd11, 1'b1, 5'b11011);
        vecs[7]  = mk(1'b1, 5'b00000, 5'b11111, 4'd8,  1'b0, 5'b11011);
        vecs[8]  = mk(1'b1, 5'b01010, 5'b00000, 4'd10, 1'b1, 5'b10001);
        vecs[9]  = mk(1'b0, 5'b00000, 5'b00000, 4'd12, 1'b0, 5'b10001);
        vecs[10] = mk(1'b0, 5'b00000, 5'b00000, 4'd2,  1'b1, 5'b10001);
        vecs[11] = mk(1'b1, 5'b00001, 5'b00000, 4'd3,  1'b1, 5'b10000);
        vecs[12] = mk(1'b0, 5'b00000, 5'b00000, 4'd4,  1'b0, 5'b10000);
        vecs[13] = mk(1'b0, 5'b00000, 5'b00000, 4'd5,  1'b1, 5'b10000);
        vecs[14] = mk(1'b0, 5'b00000, 5'b00000, 4'd6,  1'b1, 5'b10000);
        vecs[15] = mk(1'b0, 5'b00000, 5'b00000, 4'd7,  1'b0, 5'b10000);
        vecs[16] = mk(1'b1, 5'b10000, 5'b00000, 4'd7,  1'b1, 5'b00000);
        vecs[17] = mk(1'b0, 5'b00000, 5'b00000, 4'd12, 1'b1, 5'b00000);
        vecs[18] = mk(1'b0, 5'b00000, 5'b00000, 4'd13, 1'b0, 5'b00000);
        vecs[19] = mk(1'b0, 5'b00000, 5'b00000, 4'd10, 1'b1, 5'b00000);
        vecs[20] = mk(1'b0, 5'b00000, 5'b00000, 4'd0,  1'b0, 5'b00000);

        rst = 1'b1;
        alu_flags = '0; flag_wr_valid = 1'b0; flag_wr_mask = '0;
        cond_req_valid = 1'b0; cond_code = '0; cond_rsp_ready = 1'b1;
`ifdef FLAG_UNIT_PSR_WRITE_EN
        psr_wr_en = 1'b0; psr_wr_data = '0;
`endif
        tick();
        tick();
        check("reset psr", {11'd0, psr_flags}, 16'h0000);
        check("reset rsp_valid", {15'd0, cond_rsp_valid}, 16'h0000);
        check("reset taken", {15'd0, cond_taken}, 16'h0000);
        check("reset scond", scond_result, 16'h0000);
        check("reset req_ready", {15'd0, cond_req_ready}, 16'h0001);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back requests with the consumer always ready.
        for (int i = 0; i < 21; i++) begin
            flag_wr_valid  = vecs[i].wv;
            flag_wr_mask   = vecs[i].mask;
            alu_flags      = vecs[i].alu;
            cond_code      = vecs[i].cc;
            cond_req_valid = 1'b1;
            tick();
            check($sformatf("vec%0d rsp_valid", i), {15'd0, cond_rsp_valid}, 16'h0001);
            check($sformatf("vec%0d taken", i), {15'd0, cond_taken}, {15'd0, vecs[i].exp_taken});
            check($sformatf("vec%0d scond", i), scond_result, {15'd0, vecs[i].exp_taken});
            check($sformatf("vec%0d psr", i), {11'd0, psr_flags}, {11'd0, vecs[i].exp_psr});
        end
        flag_wr_valid = 1'b0; cond_req_valid = 1'b0;
        tick();
        check("idle rsp_valid", {15'd0, cond_rsp_valid}, 16'h0000);
        check("idle req_ready", {15'd0, cond_req_ready}, 16'h0001);
        check("idle taken held", {15'd0, cond_taken}, 16'h0000);

        // Consumer stall: decision and ready frozen while flags keep updating.
        cond_code = 4'd14; cond_req_valid = 1'b1;
        tick();
        check("stall first taken", {15'd0, cond_taken}, 16'h0001);
        cond_rsp_ready = 1'b0; cond_code = 4'd15;
        flag_wr_valid = 1'b1; flag_wr_mask = 5'b11111; alu_flags = 5'b00001;
        #1;
        check("stall req_ready", {15'd0, cond_req_ready}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d rsp_valid", i), {15'd0, cond_rsp_valid}, 16'h0001);
            check($sformatf("stall%0d taken", i), {15'd0, cond_taken}, 16'h0001);
            check($sformatf("stall%0d req_ready", i), {15'd0, cond_req_ready}, 16'h0000);
        end
        check("stall psr", {11'd0, psr_flags}, 16'h0001);
        flag_wr_valid = 1'b0;
        cond_rsp_ready = 1'b1;
        #1;
        check("release req_ready", {15'd0, cond_req_ready}, 16'h0001);
        tick();
        check("release rsp_valid", {15'd0, cond_rsp_valid}, 16'h0001);
        check("release taken", {15'd0, cond_taken}, 16'h0000);
        cond_req_valid = 1'b0;
        tick();
        check("release idle", {15'd0, cond_rsp_valid}, 16'h0000);

        // Asynchronous reset while a response is pending.
        cond_code = 4'd14; cond_req_valid = 1'b1;
        tick();
        cond_req_valid = 1'b0; cond_rsp_ready = 1'b0;
        check("pre-rst rsp_valid", {15'd0, cond_rsp_valid}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("async rst rsp_valid", {15'd0, cond_rsp_valid}, 16'h0000);
        check("async rst psr", {11'd0, psr_flags}, 16'h0000);
        check("async rst taken", {15'd0, cond_taken}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post-rst req_ready", {15'd0, cond_req_ready}, 16'h0001);
        check("post-rst rsp_valid", {15'd0, cond_rsp_valid}, 16'h0000);
        cond_rsp_ready = 1'b1;

`ifdef FLAG_UNIT_PSR_WRITE_EN
        // Direct load wins over the masked ALU write and feeds the bypass.
        psr_wr_en = 1'b1; psr_wr_data = 5'b10001;
        flag_wr_valid = 1'b1; flag_wr_mask = 5'b11111; alu_flags = 5'b00000;
        cond_code = 4'd6; cond_req_valid = 1'b1;
        tick();
        check("lpr psr", {11'd0, psr_flags}, 16'h0011);
        check("lpr taken", {15'd0, cond_taken}, 16'h0001);
        psr_wr_en = 1'b0; flag_wr_valid = 1'b0; cond_req_valid = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Consumer end of the ALU flag interface. Latches the C, L, F, N and Z outputs into a processor status register (PSR) under a per-instruction update mask.
- Evaluates the 16 CR16-style condition codes against the PSR for Bcond, Jcond and Scond.
- Returns a registered branch decision over a valid/ready handshake.
- Sits between the ALU and the fetch/PC control logic.

Parameters:
- WIDTH_DATA, 16, width of the Scond result word.
- WIDTH_COND, 4, condition-code field width.
- WIDTH_FLAGS, 5, number of flags held; the order is fixed as {N,Z,F,L,C}.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- alu_flags  input  5  {neg_out,zero_out,over_out,low_out,carry_out} from the ALU, so F (flag) = over_out.
- flag_wr_valid  input  1  capture the masked flags this cycle.
- flag_wr_mask  input  5  per-flag update enable, same bit order as alu_flags.
- cond_req_valid  input  1  condition evaluation request.
- cond_req_ready  output  1  unit can accept a request.
- cond_code  input  4  condition to test, sampled on the request handshake.
- cond_rsp_valid  output  1  decision available.
- cond_rsp_ready  input  1  consumer accepts the decision.
- cond_taken  output  1  condition true.
- scond_result  output  16  zero-extended cond_taken, for Scond writeback.
- psr_flags  output  5  current PSR contents.

Behaviour:
- Reset: psr_flags=0, cond_rsp_valid=0, cond_taken=0, scond_result=0, cond_req_ready=1. Reset asserted mid-transaction drops any pending response, with no partial update.
- Flag write: on a clk edge with flag_wr_valid=1, for each bit i, psr[i] <= mask[i] ? alu_flags[i] : psr[i]. If flag_wr_valid=0, the PSR holds. A mask of 0 with valid=1 is a legal no-op.
- Effective flags (bypass): eff = (flag_wr_valid ? (psr & ~mask) | (alu_flags & mask) : psr). A condition requested in the same cycle as a flag write sees the new flags. No stall is needed for a CMP followed immediately by a Bcond.
- Condition table, evaluated on eff:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 HI L; 5 LS !L; 6 GT N; 7 LE !N.
  - 8 FS F; 9 FC !F.
  - 10 LO !L&!Z; 11 HS L|Z; 12 LT !N&!Z; 13 GE N|Z.
  - 14 UC 1; 15 never 0.
- Handshake FSM, two states:
  - IDLE: cond_req_ready=1, cond_rsp_valid=0. On cond_req_valid, register cond_taken and scond_result, then go to RESP. Latency is exactly 1 cycle from request to cond_rsp_valid.
  - RESP: cond_rsp_valid=1, and outputs are stable until accepted. cond_req_ready=cond_rsp_ready, so a back-to-back request is accepted in the same cycle the response is consumed; in that case stay in RESP with the new result.
  - RESP with cond_rsp_ready=0: hold all outputs and ignore requests (ready=0). Flag writes still occur during the hold. The held decision does not change, because the condition is sampled at request time.
  - RESP with cond_rsp_ready=1 and no new request: go to IDLE.
- scond_result = {15'b0, cond_taken}, updated only when a request is accepted.
- The datapath contains no combinational path from cond_rsp_ready to cond_taken.

Optional Feature:
- Macro: FLAG_UNIT_PSR_WRITE_EN.
- When defined, add two ports:
  - psr_wr_en  input  1.
  - psr_wr_data  input  5.
  These support an LPR-style direct PSR load. psr_wr_en has priority over flag_wr_valid in the same cycle and writes all 5 bits unmasked. The bypass path uses psr_wr_data when psr_wr_en=1.
- When not defined, the ports are absent and the PSR is written only via the masked ALU path.

Test Plan:
- Reset, then request cond 14 -> cond_rsp_valid=1 one cycle later, cond_taken=1, scond_result=16'h0001. Request cond 15 -> cond_taken=0.
- alu_flags=5'b01000 (Z), mask=5'b11111, valid=1; same cycle request cond 0 (EQ) -> cond_taken=1 via the bypass; next cycle psr_flags=5'b01000.
- PSR=5'b11111; write alu_flags=0 with mask=5'b00100 (F only) -> psr_flags=5'b11011. Then cond 9 (FC) -> taken=1, cond 11 (HS) -> taken=1.
- Hold cond_rsp_ready=0 for 3 cycles with a new request pending and a flag write occurring -> cond_taken is unchanged and cond_req_ready=0. Raise ready -> the new request is accepted in the same cycle, and the response follows with no bubble.
- Assert rst while in RESP with cond_rsp_valid=1 -> cond_rsp_valid=0 and psr_flags=0 immediately (asynchronous); cond_req_ready=1 after reset release.
- With FLAG_UNIT_PSR_WRITE_EN defined: psr_wr_en=1, psr_wr_data=5'b10001, together with flag_wr_valid=1, mask=5'b11111, alu_flags=0 -> psr_flags=5'b10001. Same-cycle cond 6 (GT) -> taken=1.
